// File: rtl/mmio_keyboard.sv
// mmio_keyboard: PS/2 device-to-host receiver with a small scancode FIFO,
// drained by the CPU through single-byte reads on the shared MMIO bus.
// Reads are detected on the falling edge of the CPU phase clock, sampled
// as data on CLOCK_50. Writes to the block's addresses are ignored.
module mmio_keyboard #(
  parameter logic [15:0] DATA_ADDR      = 16'h00FF,
  parameter logic [15:0] STATUS_ADDR    = 16'h00FE,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        clock,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [7:0]  kbd_data,
  output logic        kbd_oe
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // PS/2 line synchronisers and falling-edge detect
  logic ps2_clk_meta_reg;
  logic ps2_clk_sync_reg;
  logic ps2_clk_prev_reg;
  logic ps2_dat_meta_reg;
  logic ps2_dat_sync_reg;
  logic ps2_fall;

  // Frame receiver state
  frame_state_t state_reg;
  logic [2:0]   bit_cnt_reg;
  logic [7:0]   shift_reg;
  logic         par_ok_reg;
  logic [15:0]  idle_cnt_reg;

  // CPU strobe
  logic prev_clk_reg;
  logic rd_stb;
  logic data_sel;
  logic status_sel;

  // FIFO and flags
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             frame_err_reg;
  logic             fifo_empty;
  logic             fifo_full;

  // Events
  logic stop_sample;
  logic timeout_evt;
  logic push_evt;
  logic push_ok;
  logic pop_evt;
  logic ovf_evt;
  logic frame_bad_evt;
  logic clr_evt;

  logic [3:0] cnt_sat;
  logic [7:0] status_byte;

  // Resynchronise the PS/2 lines; idle level is 1 on both
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ps2_clk_meta_reg <= 1'b1;
      ps2_clk_sync_reg <= 1'b1;
      ps2_clk_prev_reg <= 1'b1;
      ps2_dat_meta_reg <= 1'b1;
      ps2_dat_sync_reg <= 1'b1;
    end else begin
      ps2_clk_meta_reg <= PS2_CLK;
      ps2_clk_sync_reg <= ps2_clk_meta_reg;
      ps2_clk_prev_reg <= ps2_clk_sync_reg;
      ps2_dat_meta_reg <= PS2_DAT;
      ps2_dat_sync_reg <= ps2_dat_meta_reg;
    end
  end

  assign ps2_fall = ps2_clk_prev_reg & ~ps2_clk_sync_reg;

  // Stop-bit outcome and the inactivity timeout are decided from current state
  assign stop_sample   = ps2_fall && (state_reg == STOP);
  assign push_evt      = stop_sample && ps2_dat_sync_reg && par_ok_reg;
  assign timeout_evt   = (state_reg != IDLE) && !ps2_fall && (idle_cnt_reg == TIMEOUT_LAST);
  assign frame_bad_evt = (stop_sample && !(ps2_dat_sync_reg && par_ok_reg)) || timeout_evt;

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      par_ok_reg   <= 1'b0;
      idle_cnt_reg <= 16'd0;
    end else if (timeout_evt) begin
      // Abandon the partial frame; the keyboard stopped clocking
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      par_ok_reg   <= 1'b0;
      idle_cnt_reg <= 16'd0;
    end else begin
      if (state_reg == IDLE || ps2_fall) begin
        idle_cnt_reg <= 16'd0;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + 16'd1;
      end

      if (ps2_fall) begin
        case (state_reg)
          IDLE: begin
            if (!ps2_dat_sync_reg) begin
              state_reg   <= DATA;
              bit_cnt_reg <= 3'd0;
            end
          end
          DATA: begin
            shift_reg[bit_cnt_reg] <= ps2_dat_sync_reg;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
          PARITY: begin
            // Odd parity: data bits plus parity bit must hold an odd count of ones
            par_ok_reg <= ^{shift_reg, ps2_dat_sync_reg};
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  // Remember the previous CPU phase to find its falling edge
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      prev_clk_reg <= 1'b0;
    end else begin
      prev_clk_reg <= clock;
    end
  end

  assign rd_stb     = rw & prev_clk_reg & ~clock;
  assign data_sel   = (addr == DATA_ADDR);
  assign status_sel = (addr == STATUS_ADDR);

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);

  // A pop on a full FIFO frees the slot for a coincident push
  assign pop_evt = rd_stb && data_sel && !fifo_empty;
  assign push_ok = push_evt && (!fifo_full || pop_evt);
  assign ovf_evt = push_evt && fifo_full && !pop_evt;
  assign clr_evt = rd_stb && status_sel;

  // FIFO pointers and occupancy
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_evt) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_evt})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Scancode storage; contents are don't-care while the count says empty
  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= shift_reg;
    end
  end

  // Sticky error flags; a set in the same cycle as a status read wins
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow_reg <= 1'b1;
      end else if (clr_evt) begin
        overflow_reg <= 1'b0;
      end
      if (frame_bad_evt) begin
        frame_err_reg <= 1'b1;
      end else if (clr_evt) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  assign cnt_sat     = (count_reg > CNT_W'(15)) ? 4'hF : 4'(count_reg);
  assign status_byte = {cnt_sat, frame_err_reg, overflow_reg, fifo_full, ~fifo_empty};

  assign kbd_oe = rw & (data_sel | status_sel);

  // Read mux: head byte is combinational so the CPU sees it before the pop
  always_comb begin
    kbd_data = 8'h00;
    if (data_sel) begin
      if (!fifo_empty) begin
        kbd_data = fifo_mem[rd_ptr_reg];
      end
    end else if (status_sel) begin
      kbd_data = status_byte;
    end
  end

endmodule

// File: tb/tb_mmio_keyboard.sv
// Bench for mmio_keyboard: directed scenarios followed by random traffic,
// checked against a queue-based model of the scancode buffer and flags.
module tb_mmio_keyboard;

  localparam logic [15:0] DATA_ADDR   = 16'h00FF;
  localparam logic [15:0] STATUS_ADDR = 16'h00FE;
  localparam int          DEPTH       = 8;
  localparam int          TMO         = 1000;
  localparam int          HALF        = 10;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        clock    = 1'b0;
  logic [15:0] addr     = 16'h0000;
  logic        rw       = 1'b0;
  logic        PS2_CLK  = 1'b1;
  logic        PS2_DAT  = 1'b1;
  logic [7:0]  kbd_data;
  logic        kbd_oe;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [7:0] m_q[$];
  bit         m_ovf  = 1'b0;
  bit         m_ferr = 1'b0;

  mmio_keyboard #(
    .DATA_ADDR(DATA_ADDR),
    .STATUS_ADDR(STATUS_ADDR),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .clock(clock),
    .addr(addr),
    .rw(rw),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .kbd_data(kbd_data),
    .kbd_oe(kbd_oe)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  function automatic logic [7:0] model_status();
    int c;
    int s;
    c = m_q.size();
    s = (c > 15) ? 15 : c;
    return {4'(s), m_ferr, m_ovf, (c == DEPTH), (c != 0)};
  endfunction

  function automatic logic [7:0] model_head();
    return (m_q.size() != 0) ? m_q[0] : 8'h00;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) m_ferr = 1'b1;
    else if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  // One CPU read cycle: phase high, sample, phase low (strobe), release
  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output logic oe);
    addr  = a;
    rw    = 1'b1;
    clock = 1'b1;
    wait_cyc(1);
    d  = kbd_data;
    oe = kbd_oe;
    clock = 1'b0;
    wait_cyc(1);
    rw = 1'b0;
    wait_cyc(1);
  endtask

  task automatic read_data(input string tag);
    logic [7:0] d;
    logic oe;
    logic [7:0] exp;
    exp = model_head();
    cpu_read(DATA_ADDR, d, oe);
    check_val({tag, "_oe"}, 16'(oe), 16'h1);
    check_val(tag, 16'(d), 16'(exp));
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d;
    logic oe;
    logic [7:0] exp;
    exp = model_status();
    cpu_read(STATUS_ADDR, d, oe);
    check_val(tag, 16'(d), 16'(exp));
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a);
    addr  = a;
    rw    = 1'b0;
    clock = 1'b1;
    wait_cyc(1);
    check_val("wr_oe", 16'(kbd_oe), 16'h0);
    clock = 1'b0;
    wait_cyc(2);
  endtask

  task automatic read_other();
    logic [7:0] d;
    logic oe;
    logic [15:0] a;
    a = 16'($urandom_range(0, 16'hFFFD));
    cpu_read(a, d, oe);
    check_val("other_oe", 16'(oe), 16'h0);
    check_val("other_data", 16'(d), 16'h0);
  endtask

  // Send the first nbits of a PS/2 frame; optionally align a data read
  // with the stop-bit falling edge
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit pop_at_stop);
    logic [10:0] bits;
    logic [7:0]  exp;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = bits[i];
      wait_cyc(HALF);
      if (pop_at_stop && i == 10) begin
        addr  = DATA_ADDR;
        rw    = 1'b1;
        clock = 1'b1;
      end
      PS2_CLK = 1'b0;
      if (pop_at_stop && i == 10) begin
        wait_cyc(2);
        exp = model_head();
        check_val("coinc_head", 16'(kbd_data), 16'(exp));
        clock = 1'b0;
        wait_cyc(1);
        rw = 1'b0;
        if (m_q.size() != 0) void'(m_q.pop_front());
        wait_cyc(HALF - 3);
      end else begin
        wait_cyc(HALF);
      end
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    wait_cyc(HALF);
    if (nbits == 11) model_frame(b, !(bad_par || bad_stop));
  endtask

  task automatic do_reset();
    wait_cyc(1);
    #2;
    reset = 1'b0;
    addr  = DATA_ADDR;
    rw    = 1'b1;
    #1;
    check_val("rst_async_data", 16'(kbd_data), 16'h0);
    m_q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    rw = 1'b0;
    clock = 1'b0;
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(2);
  endtask

  initial begin
    logic [7:0] d;
    logic oe;
    int op;
    logic [7:0] rb;

    reset = 1'b0;
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(5);

    // Reset state
    read_status("rst_status");
    read_data("rst_data");

    // Single good frame
    send_frame(8'h1C, 0, 0, 11, 0);
    cpu_read(STATUS_ADDR, d, oe);
    check_val("single_status", 16'(d), 16'h11);
    read_data("single_data");
    read_status("single_status2");

    // Bad parity, then bad stop bit
    send_frame(8'h1C, 1, 0, 11, 0);
    send_frame(8'h32, 0, 1, 11, 0);
    cpu_read(STATUS_ADDR, d, oe);
    check_val("badframe_status", 16'(d), 16'h08);
    m_ferr = 1'b0;
    read_status("badframe_clear");

    // Timeout on a partial frame, then a good frame
    send_frame(8'hA5, 0, 0, 5, 0);
    wait_cyc(TMO + TMO / 5);
    m_ferr = 1'b1;
    read_status("timeout_status");
    send_frame(8'hF0, 0, 0, 11, 0);
    read_status("timeout_next_status");
    read_data("timeout_next_data");

    // Overflow and pointer wrap
    for (int i = 1; i <= 10; i++) send_frame(8'(i), 0, 0, 11, 0);
    cpu_read(STATUS_ADDR, d, oe);
    check_val("ovf_status", 16'(d), 16'h87);
    m_ovf = 1'b0;
    for (int i = 0; i < 10; i++) read_data("ovf_drain");
    for (int i = 0; i < 5; i++) send_frame(8'h40 + 8'(i), 0, 0, 11, 0);
    for (int i = 0; i < 5; i++) read_data("wrap_data");

    // Push and pop coinciding with a full FIFO
    for (int i = 0; i < DEPTH; i++) send_frame(8'h60 + 8'(i), 0, 0, 11, 0);
    send_frame(8'h7E, 0, 0, 11, 1);
    read_status("coinc_status");
    for (int i = 0; i < DEPTH; i++) read_data("coinc_drain");

    // Reset in the middle of a frame with bytes queued
    for (int i = 0; i < 3; i++) send_frame(8'h90 + 8'(i), 0, 0, 11, 0);
    send_frame(8'h55, 0, 0, 6, 0);
    do_reset();
    read_status("midrst_status");
    send_frame(8'h2B, 0, 0, 11, 0);
    read_data("midrst_data");

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      rb = 8'($urandom);
      case (op)
        0, 1, 2, 3: send_frame(rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 11, 0);
        4, 5:       read_data("rnd_data");
        6:          read_status("rnd_status");
        7:          cpu_write(($urandom_range(0, 1) == 1) ? DATA_ADDR : STATUS_ADDR);
        8:          read_other();
        default:    send_frame(rb, 0, 0, 11, 1);
      endcase
    end
    read_status("final_status");
    for (int i = 0; i < DEPTH; i++) read_data("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
